// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM and the MIPS datapath.
// The master side is the controller: it reads the opcode and memory ready,
// and drives every enable and mux select.
interface multicycle_control_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       aluop1;
  logic       aluop0;
  logic [1:0] pcsource;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  op, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
           regwrite, alusrca, alusrcb, aluop1, aluop0, pcsource, instr_done, illegal_op
  );

  modport slave (
    output op, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
           regwrite, alusrca, alusrcb, aluop1, aluop0, pcsource, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. Sequences fetch, decode,
// execute, memory and writeback for R-type, lw, sw, beq, j and addi, and
// stalls in the memory states until mem_ready.
module multicycle_control (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_control_if.master   bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRComp  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] op_q;

  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, aluop1, aluop0;
  logic       instr_done, illegal_op;
  logic [1:0] alusrcb, pcsource;

  // State register and opcode latch; op is captured in DECODE for MEMADR's branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      op_q    <= 6'h00;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) op_q <= bus.op;
    end
  end

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = bus.mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StExec;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
          OP_ADDI:      state_d = StAddiEx;
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (op_q == OP_SW) ? StMemWr : StMemRd;
      StMemRd:  state_d = bus.mem_ready ? StMemWb : StMemRd;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = bus.mem_ready ? StFetch : StMemWr;
      StExec:   state_d = StRComp;
      StRComp:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Moore output decode; only FETCH/MEMWR strobes and DECODE's illegal flag look at inputs.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop1      = 1'b0;
    aluop0      = 1'b0;
    pcsource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (state_q)
      StFetch: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = bus.mem_ready;
        pcwrite = bus.mem_ready;
      end
      StDecode: begin
        alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
          default:                                       illegal_op = 1'b1;
        endcase
      end
      StMemAdr, StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRd: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      StMemWb: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
      end
      StMemWr: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = bus.mem_ready;
      end
      StExec: begin
        alusrca = 1'b1;
        aluop1  = 1'b1;
      end
      StRComp: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        alusrca     = 1'b1;
        aluop0      = 1'b1;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
        instr_done  = 1'b1;
      end
      StJump: begin
        pcwrite    = 1'b1;
        pcsource   = 2'b10;
        instr_done = 1'b1;
      end
      StAddiWb: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are killed combinationally so reset aborts a memory access in the same cycle.
  assign bus.pcwrite     = pcwrite & ~reset;
  assign bus.pcwritecond = pcwritecond & ~reset;
  assign bus.irwrite     = irwrite & ~reset;
  assign bus.regwrite    = regwrite & ~reset;
  assign bus.memread     = memread & ~reset;
  assign bus.memwrite    = memwrite & ~reset;
  assign bus.instr_done  = instr_done & ~reset;
  assign bus.illegal_op  = illegal_op & ~reset;
  assign bus.iord        = iord;
  assign bus.memtoreg    = memtoreg;
  assign bus.regdst      = regdst;
  assign bus.alusrca     = alusrca;
  assign bus.alusrcb     = alusrcb;
  assign bus.aluop1      = aluop1;
  assign bus.aluop0      = aluop0;
  assign bus.pcsource    = pcsource;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each cycle compares the full control
// word against a hand-written table of per-state values.
module tb_multicycle_control;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   done_cnt;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Field order: pw pwc iord mrd mwr irw m2r rdst rw asa | asb a1 a0 | ps done ill
  logic [17:0] obs;
  assign obs = {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
                bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca,
                bus.alusrcb, bus.aluop1, bus.aluop0, bus.pcsource, bus.instr_done,
                bus.illegal_op};

  logic [7:0] enables;
  assign enables = {bus.pcwrite, bus.pcwritecond, bus.irwrite, bus.regwrite, bus.memread,
                    bus.memwrite, bus.instr_done, bus.illegal_op};

  localparam logic [17:0] FETCH_RDY = 18'b1001010000_0100_0000;
  localparam logic [17:0] FETCH_STL = 18'b0001000000_0100_0000;
  localparam logic [17:0] DECODE    = 18'b0000000000_1100_0000;
  localparam logic [17:0] DEC_ILL   = 18'b0000000000_1100_0001;
  localparam logic [17:0] MEMADR    = 18'b0000000001_1000_0000;
  localparam logic [17:0] MEMRD     = 18'b0011000000_0000_0000;
  localparam logic [17:0] MEMWB     = 18'b0000001010_0000_0010;
  localparam logic [17:0] MEMWR_RDY = 18'b0010100000_0000_0010;
  localparam logic [17:0] MEMWR_STL = 18'b0010100000_0000_0000;
  localparam logic [17:0] EXEC      = 18'b0000000001_0010_0000;
  localparam logic [17:0] RCOMP     = 18'b0000000110_0000_0010;
  localparam logic [17:0] BRANCH    = 18'b0100000001_0001_0110;
  localparam logic [17:0] JUMP      = 18'b1000000000_0000_1010;
  localparam logic [17:0] ADDI_EX   = 18'b0000000001_1000_0000;
  localparam logic [17:0] ADDI_WB   = 18'b0000000010_0000_0010;
  localparam logic [17:0] MEMWR_RST = 18'b0010000000_0000_0000;

  always @(posedge clk) if (bus.instr_done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle, advance past the edge.
  task automatic cyc(input string tag, input logic mr, input logic [5:0] o,
                     input logic [17:0] e);
    bus.mem_ready = mr;
    bus.op        = o;
    @(negedge clk);
    check(tag, {14'd0, obs}, {14'd0, e});
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    done_cnt      = 0;
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.op        = 6'h00;

    // 1: reset held three cycles, enables must stay low throughout
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_enables", {24'd0, enables}, 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    cyc("rel_fetch", 1'b1, 6'h00, FETCH_RDY);

    // 2: stream R, lw, sw, beq, j, addi (R's FETCH was the cycle above)
    cyc("r_dec",     1'b1, 6'h00, DECODE);
    cyc("r_exec",    1'b1, 6'h00, EXEC);
    cyc("r_rcomp",   1'b1, 6'h00, RCOMP);
    cyc("lw_fetch",  1'b1, 6'h00, FETCH_RDY);
    cyc("lw_dec",    1'b1, 6'h23, DECODE);
    cyc("lw_adr",    1'b1, 6'h2b, MEMADR);   // live op changed: latched lw must win
    cyc("lw_rd",     1'b1, 6'h00, MEMRD);
    cyc("lw_wb",     1'b1, 6'h00, MEMWB);
    cyc("sw_fetch",  1'b1, 6'h00, FETCH_RDY);
    cyc("sw_dec",    1'b1, 6'h2b, DECODE);
    cyc("sw_adr",    1'b1, 6'h23, MEMADR);
    cyc("sw_wr",     1'b1, 6'h00, MEMWR_RDY);
    cyc("beq_fetch", 1'b1, 6'h00, FETCH_RDY);
    cyc("beq_dec",   1'b1, 6'h04, DECODE);
    cyc("beq_br",    1'b1, 6'h00, BRANCH);
    cyc("j_fetch",   1'b1, 6'h00, FETCH_RDY);
    cyc("j_dec",     1'b1, 6'h02, DECODE);
    cyc("j_jump",    1'b1, 6'h00, JUMP);
    cyc("ad_fetch",  1'b1, 6'h00, FETCH_RDY);
    cyc("ad_dec",    1'b1, 6'h08, DECODE);
    cyc("ad_ex",     1'b1, 6'h00, ADDI_EX);
    cyc("ad_wb",     1'b1, 6'h00, ADDI_WB);
    check("stream_done_cnt", done_cnt, 32'd6);

    // 3: lw with two FETCH stalls and three MEMRD stalls -> 10 cycles
    cyc("lws_f0",    1'b0, 6'h00, FETCH_STL);
    cyc("lws_f1",    1'b0, 6'h00, FETCH_STL);
    cyc("lws_f2",    1'b1, 6'h00, FETCH_RDY);
    cyc("lws_dec",   1'b0, 6'h23, DECODE);   // mem_ready ignored in DECODE
    cyc("lws_adr",   1'b0, 6'h23, MEMADR);
    cyc("lws_rd0",   1'b0, 6'h00, MEMRD);
    cyc("lws_rd1",   1'b0, 6'h00, MEMRD);
    cyc("lws_rd2",   1'b0, 6'h00, MEMRD);
    cyc("lws_rd3",   1'b1, 6'h00, MEMRD);
    cyc("lws_wb",    1'b0, 6'h00, MEMWB);
    check("lw_stall_done_cnt", done_cnt, 32'd7);

    // 4: undecoded opcode
    cyc("ill_fetch", 1'b1, 6'h00, FETCH_RDY);
    cyc("ill_dec",   1'b1, 6'h3f, DEC_ILL);
    cyc("ill_next",  1'b1, 6'h00, FETCH_RDY);

    // 5: reset during a stalled store
    cyc("rsw_dec",   1'b1, 6'h2b, DECODE);
    cyc("rsw_adr",   1'b1, 6'h00, MEMADR);
    cyc("rsw_wr",    1'b0, 6'h00, MEMWR_STL);
    reset = 1'b1;
    cyc("rsw_rst",   1'b0, 6'h00, MEMWR_RST);
    reset = 1'b0;
    cyc("rsw_fetch", 1'b1, 6'h00, FETCH_RDY);
    check("final_done_cnt", done_cnt, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
